// File: rtl/gpc_arith_pkg.sv
// gpc_arith_pkg: shared constants and types for the sequential 32-bit subtractor.
package gpc_arith_pkg;

    localparam int unsigned SLICE_W  = 8;
    localparam int unsigned N_SLICES = 4;
    localparam int unsigned DATA_W   = SLICE_W * N_SLICES;
    localparam int unsigned CNT_W    = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sub32_state_t;

    // {borrow, diff}
    typedef logic [DATA_W:0] sub32_result_t;

endpackage

// File: rtl/sub8_slice.sv
// sub8_slice: combinational 8-bit subtract with borrow-in/borrow-out.
// Also exports the borrow into the MSB so the caller can derive signed overflow.
module sub8_slice
    import gpc_arith_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               bin,
    output logic [SLICE_W-1:0] diff,
    output logic               bout,
    output logic               bmsb
);

    logic [SLICE_W-1:0] lo_res;
    logic [1:0]         hi_res;

    // Low bits first; the top bit of lo_res is the borrow into the MSB.
    always_comb begin
        lo_res = {1'b0, a[SLICE_W-2:0]} - {1'b0, b[SLICE_W-2:0]}
               - {{(SLICE_W-1){1'b0}}, bin};
        hi_res = {1'b0, a[SLICE_W-1]} - {1'b0, b[SLICE_W-1]} - {1'b0, lo_res[SLICE_W-1]};
        diff   = {hi_res[0], lo_res[SLICE_W-2:0]};
        bout   = hi_res[1];
        bmsb   = lo_res[SLICE_W-1];
    end

endmodule

// File: rtl/sub32_seq.sv
// sub32_seq: multi-cycle 32-bit subtractor, a - b - bin, one 8-bit slice per clock.
// Result is {borrow, diff}. Optional zero/neg/ovf flags are built when
// SUB32_SEQ_FLAGS_EN is defined.
module sub32_seq
    import gpc_arith_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                bin,
    output logic                out_valid,
    input  logic                out_ready,
`ifdef SUB32_SEQ_FLAGS_EN
    output logic                zero,
    output logic                neg,
    output logic                ovf,
`endif
    output sub32_result_t       out
);

    sub32_state_t       state_q, state_d;
    logic [DATA_W-1:0]  a_q, b_q, diff_q, diff_d;
    logic               brw_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               last_slice;

    logic [SLICE_W-1:0] a_s, b_s, d_s;
    logic               bout_s, bmsb_s;

`ifdef SUB32_SEQ_FLAGS_EN
    logic               zero_q, neg_q, ovf_q;
`endif

    assign last_slice = (cnt_q == CNT_W'(N_SLICES - 1));
    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out        = {brw_q, diff_q};

`ifdef SUB32_SEQ_FLAGS_EN
    assign zero = zero_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;
`endif

    // Route the active slice of the latched operands into the shared slice adder
    // and merge its result back into the difference word.
    always_comb begin
        a_s    = a_q[7:0];
        b_s    = b_q[7:0];
        diff_d = diff_q;
        case (cnt_q)
            2'd0: begin
                a_s          = a_q[7:0];
                b_s          = b_q[7:0];
                diff_d[7:0]  = d_s;
            end
            2'd1: begin
                a_s          = a_q[15:8];
                b_s          = b_q[15:8];
                diff_d[15:8] = d_s;
            end
            2'd2: begin
                a_s           = a_q[23:16];
                b_s           = b_q[23:16];
                diff_d[23:16] = d_s;
            end
            default: begin
                a_s           = a_q[31:24];
                b_s           = b_q[31:24];
                diff_d[31:24] = d_s;
            end
        endcase
    end

    sub8_slice u_slice (
        .a    (a_s),
        .b    (b_s),
        .bin  (brw_q),
        .diff (d_s),
        .bout (bout_s),
        .bmsb (bmsb_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; out_ready only matters once the result is held.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last_slice) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then one slice per clock while running.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            diff_q <= '0;
            brw_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (state_q == IDLE && in_valid) begin
                a_q   <= a;
                b_q   <= b;
                brw_q <= bin;
                cnt_q <= '0;
            end else if (state_q == RUN) begin
                diff_q <= diff_d;
                brw_q  <= bout_s;
                cnt_q  <= cnt_q + 1'b1;
            end
        end
    end

`ifdef SUB32_SEQ_FLAGS_EN
    // Flags are captured with the final slice so they freeze together with out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state_q == RUN && last_slice) begin
            zero_q <= (diff_d == '0);
            neg_q  <= diff_d[DATA_W-1];
            ovf_q  <= bmsb_s ^ bout_s;
        end
    end
`endif

endmodule

// File: tb/tb_sub32_seq.sv
// tb_sub32_seq: directed self-checking bench for sub32_seq.
// Flag checks are compiled in only when SUB32_SEQ_FLAGS_EN is defined.
module tb_sub32_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [32:0] out;
`ifdef SUB32_SEQ_FLAGS_EN
    logic        zero, neg, ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sub32_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SUB32_SEQ_FLAGS_EN
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf),
`endif
        .out       (out)
    );

    // Drives one operation, holds out_ready low until out_valid, then consumes it.
    // Returns the result, the flags (0 when absent) and accept-to-valid latency.
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic ibin,
                          output logic [32:0] res, output logic [2:0] flg, output int lat);
        in_valid  = 1'b1;
        a         = ia;
        b         = ib;
        bin       = ibin;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        // Busy: scramble operands with in_valid high; these must be ignored.
        a   = $urandom;
        b   = $urandom;
        bin = 1'b1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        res      = out;
`ifdef SUB32_SEQ_FLAGS_EN
        flg = {zero, neg, ovf};
`else
        flg = 3'b000;
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        n_cmp++;
        if (out !== 33'h0) begin
            n_err++; $display("FAIL reset_out got %h want 0", out);
        end
`ifdef SUB32_SEQ_FLAGS_EN
        n_cmp++;
        if ({zero, neg, ovf} !== 3'b000) begin
            n_err++; $display("FAIL reset_flags got %b want 000", {zero, neg, ovf});
        end
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [32:0] r;
        logic [2:0]  f;
        int          lat;
        run_op(32'd5, 32'd3, 1'b0, r, f, lat);
        n_cmp++;
        if (lat !== 4) begin
            n_err++; $display("FAIL basic_latency got %0d want 4", lat);
        end
        n_cmp++;
        if (r !== 33'h0_0000_0002) begin
            n_err++; $display("FAIL basic_out got %h want 000000002", r);
        end
`ifdef SUB32_SEQ_FLAGS_EN
        n_cmp++;
        if (f !== 3'b000) begin
            n_err++; $display("FAIL basic_flags got %b want 000", f);
        end
`endif
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL basic_consume got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_underflow();
        logic [32:0] r;
        logic [2:0]  f;
        int          lat;
        run_op(32'd0, 32'd1, 1'b0, r, f, lat);
        n_cmp++;
        if (r !== 33'h1_FFFF_FFFF) begin
            n_err++; $display("FAIL underflow_out got %h want 1ffffffff", r);
        end
`ifdef SUB32_SEQ_FLAGS_EN
        n_cmp++;
        if (f !== 3'b010) begin
            n_err++; $display("FAIL underflow_flags got %b want 010", f);
        end
`endif
        // Borrow-in alone drives the result negative.
        run_op(32'd0, 32'd0, 1'b1, r, f, lat);
        n_cmp++;
        if (r !== 33'h1_FFFF_FFFF) begin
            n_err++; $display("FAIL bin_only_out got %h want 1ffffffff", r);
        end
        // Equal-all-ones operands with borrow-in still borrow.
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, r, f, lat);
        n_cmp++;
        if (r !== 33'h1_FFFF_FFFF) begin
            n_err++; $display("FAIL ones_bin_out got %h want 1ffffffff", r);
        end
        // a == b + bin exactly: no borrow.
        run_op(32'd1, 32'd0, 1'b1, r, f, lat);
        n_cmp++;
        if (r !== 33'h0_0000_0000) begin
            n_err++; $display("FAIL exact_zero_out got %h want 000000000", r);
        end
    endtask

    task automatic test_borrow_chain();
        logic [32:0] r;
        logic [2:0]  f;
        int          lat;
        run_op(32'h0100_0000, 32'd1, 1'b0, r, f, lat);
        n_cmp++;
        if (r !== 33'h0_00FF_FFFF) begin
            n_err++; $display("FAIL chain_out got %h want 000ffffff", r);
        end
        run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, r, f, lat);
        n_cmp++;
        if (r !== 33'h0_0000_0000) begin
            n_err++; $display("FAIL equal_out got %h want 000000000", r);
        end
`ifdef SUB32_SEQ_FLAGS_EN
        n_cmp++;
        if (f !== 3'b100) begin
            n_err++; $display("FAIL equal_flags got %b want 100", f);
        end
`endif
        run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0, r, f, lat);
        n_cmp++;
        if (r !== 33'h0_0246_8ACF) begin
            n_err++; $display("FAIL mixed_out got %h want 002468acf", r);
        end
    endtask

    task automatic test_ovf();
        logic [32:0] r;
        logic [2:0]  f;
        int          lat;
        run_op(32'h8000_0000, 32'd0, 1'b1, r, f, lat);
        n_cmp++;
        if (r !== 33'h0_7FFF_FFFF) begin
            n_err++; $display("FAIL ovf_out got %h want 07fffffff", r);
        end
`ifdef SUB32_SEQ_FLAGS_EN
        n_cmp++;
        if (f !== 3'b001) begin
            n_err++; $display("FAIL ovf_flags got %b want 001", f);
        end
`endif
    endtask

    task automatic test_backpressure();
        int lat;
        in_valid  = 1'b1;
        a         = 32'd100;
        b         = 32'd1;
        bin       = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        a   = 32'd7;
        b   = 32'd7;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_cmp++;
        if (lat !== 4) begin
            n_err++; $display("FAIL bp_latency got %0d want 4", lat);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (out !== 33'h0_0000_0063 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d got out=%h v=%b r=%b want out=000000063 v=1 r=0",
                         i, out, out_valid, in_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_release got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [32:0] r;
        logic [2:0]  f;
        int          lat;
        in_valid = 1'b1;
        a        = 32'hFFFF_FFFF;
        b        = 32'h0000_1234;
        bin      = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 33'h0) begin
            n_err++;
            $display("FAIL midrst_state got v=%b r=%b out=%h want v=0 r=1 out=0",
                     out_valid, in_ready, out);
        end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL midrst_no_valid got %b want 0", out_valid);
        end
        run_op(32'd10, 32'd4, 1'b0, r, f, lat);
        n_cmp++;
        if (r !== 33'h0_0000_0006) begin
            n_err++; $display("FAIL midrst_next got %h want 000000006", r);
        end
    endtask

    task automatic test_back_to_back();
        int          k;
        int          vcnt;
        logic [32:0] vres;
        in_valid  = 1'b1;
        a         = 32'd20;
        b         = 32'd5;
        bin       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        a    = 32'd30;
        b    = 32'd8;
        k    = 0;
        vcnt = 0;
        vres = '0;
        while (!in_ready && k < 20) begin
            @(posedge clk);
            #1;
            k++;
            if (out_valid) begin
                vcnt++;
                vres = out;
            end
        end
        n_cmp++;
        if (k !== 5) begin
            n_err++; $display("FAIL b2b_idle_at got %0d want 5", k);
        end
        n_cmp++;
        if (vcnt !== 1 || vres !== 33'h0_0000_000F) begin
            n_err++; $display("FAIL b2b_first got cnt=%0d out=%h want cnt=1 out=00000000f",
                              vcnt, vres);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL b2b_reaccept got in_ready=%b want 0", in_ready);
        end
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_cmp++;
        if (k !== 4 || out !== 33'h0_0000_0016) begin
            n_err++; $display("FAIL b2b_second got lat=%0d out=%h want lat=4 out=000000016",
                              k, out);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_borrow_chain();
        test_ovf();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
